// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage sitting directly in front of a combinational instruction
//   memory. Owns the PC, presents the word address, and captures the returned
//   instruction together with its byte PC in an IF/ID register that hands off
//   to the decoder through a valid/ready handshake. Handles branch/jump
//   redirects, decoder backpressure and a halt request.
//
//   Optional feature macro: IFETCH_PERF_EN
//     When defined, two 32-bit wrapping performance counters are exposed:
//       perf_fetch_cnt - instructions accepted into IF/ID
//       perf_stall_cnt - S_RUN cycles lost to decoder backpressure
//     When undefined, the ports and counters are not present.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter int                  MEMORY_SIZE      = 1024,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_target,
    input  logic                        halt_req,
    input  logic                        id_ready,
    output logic                        id_valid,
    output logic [INSTRUCTION_SIZE-1:0] id_instruction,
    output logic [WORDSIZE-1:0]         id_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_stall_cnt,
`endif
    output logic                        halted
);

    // Canonical RISC-V NOP (addi x0, x0, 0); also substituted for reads past
    // the end of the instruction memory.
    localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTR = INSTRUCTION_SIZE'(32'h0000_0013);
    localparam logic [WORDSIZE-1:0]         PC_STEP   = WORDSIZE'(4);
    localparam logic [WORDSIZE-1:0]         MEM_WORDS = WORDSIZE'(MEMORY_SIZE);
    localparam logic [WORDSIZE-1:0]         ALIGN_MSK = ~WORDSIZE'(3);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Architectural state
    state_t                        r_state;
    logic [WORDSIZE-1:0]           r_pc;
    logic                          r_id_valid;
    logic [INSTRUCTION_SIZE-1:0]   r_id_instruction;
    logic [WORDSIZE-1:0]           r_id_pc;
    logic                          r_halted;

    // Combinational control
    state_t                        w_next_state;
    logic [WORDSIZE-1:0]           w_pc_next;
    logic                          w_id_valid_next;
    logic                          w_do_fetch;
    logic                          w_stall_cycle;
    logic                          w_adv;
    logic [WORDSIZE-1:0]           w_word_addr;
    logic                          w_in_range;
    logic [INSTRUCTION_SIZE-1:0]   w_fetch_word;
    logic [WORDSIZE-1:0]           w_redirect_pc;
    logic [WORDSIZE-1:0]           w_pc_plus4;

    // Word address is the byte PC with the two byte-offset bits dropped.
    assign w_word_addr   = {2'b00, r_pc[WORDSIZE-1:2]};
    assign imem_addr     = w_word_addr;

    // Anything past the populated memory reads as a NOP so the pipeline keeps
    // flowing instead of decoding garbage.
    assign w_in_range    = (w_word_addr < MEM_WORDS);
    assign w_fetch_word  = w_in_range ? imem_instruction : NOP_INSTR;

    // Redirect targets are forced to word alignment; pc+4 wraps naturally.
    assign w_redirect_pc = redirect_target & ALIGN_MSK;
    assign w_pc_plus4    = r_pc + PC_STEP;

    // The IF/ID slot can take a new word when empty or being drained this cycle.
    assign w_adv         = !r_id_valid || id_ready;

    // Next-state and per-cycle action selection: redirect beats stall beats fetch.
    always_comb begin
        w_next_state    = r_state;
        w_pc_next       = r_pc;
        w_id_valid_next = r_id_valid;
        w_do_fetch      = 1'b0;
        w_stall_cycle   = 1'b0;

        case (r_state)
            S_BOOT: begin
                // One idle cycle after reset; a redirect here still lands.
                w_next_state = S_RUN;
                if (redirect_valid) begin
                    w_pc_next       = w_redirect_pc;
                    w_id_valid_next = 1'b0;
                end
            end

            S_RUN: begin
                if (redirect_valid) begin
                    // Flush IF/ID even under backpressure; a pending halt is
                    // deferred by one cycle.
                    w_pc_next       = w_redirect_pc;
                    w_id_valid_next = 1'b0;
                end else if (halt_req) begin
                    // Stop issuing; let the current IF/ID entry drain.
                    w_next_state  = S_HALT;
                    w_stall_cycle = !w_adv;
                    if (id_ready) begin
                        w_id_valid_next = 1'b0;
                    end
                end else if (!w_adv) begin
                    w_stall_cycle = 1'b1;
                end else begin
                    w_do_fetch      = 1'b1;
                    w_pc_next       = w_pc_plus4;
                    w_id_valid_next = 1'b1;
                end
            end

            S_HALT: begin
                if (redirect_valid) begin
                    w_pc_next       = w_redirect_pc;
                    w_id_valid_next = 1'b0;
                end else if (id_ready) begin
                    w_id_valid_next = 1'b0;
                end
                if (!halt_req) begin
                    w_next_state = S_RUN;
                end
            end

            default: begin
                w_next_state    = S_BOOT;
                w_id_valid_next = 1'b0;
            end
        endcase
    end

    // Control state: FSM, PC, IF/ID valid and the registered halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc_next;
            r_id_valid <= w_id_valid_next;
            // Computed from next-cycle values so halted lines up with the
            // registered state and valid it describes.
            r_halted   <= (w_next_state == S_HALT) && !w_id_valid_next;
        end
    end

    // IF/ID payload: loaded only on an accepted fetch, otherwise held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_instruction <= NOP_INSTR;
            r_id_pc          <= '0;
        end else if (w_do_fetch) begin
            r_id_instruction <= w_fetch_word;
            r_id_pc          <= r_pc;
        end
    end

    assign id_valid       = r_id_valid;
    assign id_instruction = r_id_instruction;
    assign id_pc          = r_id_pc;
    assign halted         = r_halted;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Free-running event counters; wrap silently at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_do_fetch) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_stall_cycle) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed scenarios for reset, sequential fetch, stall, redirect, memory
//   boundary, PC wrap, halt and reset-during-stall, followed by a randomized
//   run compared cycle by cycle against a behavioural model of the fetch
//   stage. Performance counters are checked when IFETCH_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int          WS  = 64;
    localparam int          IS  = 32;
    localparam int          MS  = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [WS-1:0] imem_addr;
    logic [IS-1:0] imem_instruction;
    logic          redirect_valid;
    logic [WS-1:0] redirect_target;
    logic          halt_req;
    logic          id_ready;
    logic          id_valid;
    logic [IS-1:0] id_instruction;
    logic [WS-1:0] id_pc;
    logic          halted;
`ifdef IFETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:MS-1];

    // Reference model state
    logic [WS-1:0] m_pc;
    logic          m_valid;
    logic [IS-1:0] m_instr;
    logic [WS-1:0] m_idpc;
    int            m_mode;
    logic          m_halted;
    logic [31:0]   m_fc;
    logic [31:0]   m_sc;

    instruction_fetch_unit #(
        .WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .MEMORY_SIZE(MS), .RESET_PC('0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_instruction(imem_instruction),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .halt_req(halt_req),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_instruction(id_instruction),
        .id_pc(id_pc),
`ifdef IFETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: in range returns stored words, beyond it returns junk
    // that the DUT must replace with a NOP.
    always_comb begin
        if (imem_addr < 64'(MS)) imem_instruction = mem[imem_addr[9:0]];
        else                     imem_instruction = 32'hDEAD_0000 ^ imem_addr[31:0];
    end

    function automatic logic [31:0] model_fetch(input logic [WS-1:0] pc);
        logic [WS-1:0] w;
        w = pc / 4;
        if (w < 64'(MS)) return mem[w[9:0]];
        return NOP;
    endfunction

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic model_step();
        bit accept;
        bit redir;
        logic [WS-1:0] tgt;
        redir  = redirect_valid;
        tgt    = redirect_target - (redirect_target % 4);
        accept = !m_valid || id_ready;
        if (reset) begin
            m_pc = '0; m_valid = 0; m_instr = NOP; m_idpc = '0;
            m_mode = M_BOOT; m_halted = 0; m_fc = 0; m_sc = 0;
            return;
        end
        if (m_mode == M_BOOT) begin
            if (redir) m_pc = tgt;
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (redir) begin
                m_pc = tgt; m_valid = 0;
            end else begin
                if (!accept) m_sc = m_sc + 1;
                if (halt_req) begin
                    if (id_ready) m_valid = 0;
                    m_mode = M_HALT;
                end else if (accept) begin
                    m_instr = model_fetch(m_pc);
                    m_idpc  = m_pc;
                    m_valid = 1;
                    m_pc    = m_pc + 4;
                    m_fc    = m_fc + 1;
                end
            end
        end else begin
            if (redir)         begin m_pc = tgt; m_valid = 0; end
            else if (id_ready) m_valid = 0;
            if (!halt_req) m_mode = M_RUN;
        end
        m_halted = (m_mode == M_HALT) && !m_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; redirect_valid = 0; redirect_target = '0; halt_req = 0; id_ready = 1;
        tick(); tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr, halted} !== {1'b0, 64'h0, NOP, 64'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got v=%b pc=%h ins=%h addr=%h halted=%b want v=0 pc=0 ins=%h addr=0 halted=0",
                     id_valid, id_pc, id_instruction, imem_addr, halted, NOP);
        end
    endtask

    task automatic test_sequential_fetch();
        reset = 0;
        tick();
        checks++;
        if ({id_valid, imem_addr} !== {1'b0, 64'h0}) begin
            failures++;
            $display("FAIL boot_idle got v=%b addr=%h want v=0 addr=0", id_valid, imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'(4*k), mem[k], 64'(k+1)}) begin
                failures++;
                $display("FAIL seq_fetch%0d got v=%b pc=%h ins=%h addr=%h want v=1 pc=%h ins=%h addr=%h",
                         k, id_valid, id_pc, id_instruction, imem_addr, 64'(4*k), mem[k], 64'(k+1));
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'd12, mem[3], 64'd4}) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h addr=%h want v=1 pc=c ins=%h addr=4",
                         k, id_valid, id_pc, id_instruction, imem_addr, mem[3]);
            end
        end
        id_ready = 1;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'd16, mem[4], 64'd5}) begin
            failures++;
            $display("FAIL stall_resume got pc=%h ins=%h addr=%h want pc=10 ins=%h addr=5",
                     id_pc, id_instruction, imem_addr, mem[4]);
        end
    endtask

    task automatic test_redirect();
        id_ready = 0; redirect_valid = 1; redirect_target = 64'h2E;
        tick();
        checks++;
        if ({id_valid, imem_addr} !== {1'b0, 64'd11}) begin
            failures++;
            $display("FAIL redirect_flush got v=%b addr=%h want v=0 addr=b", id_valid, imem_addr);
        end
        redirect_valid = 0; id_ready = 1;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'h2C, mem[11], 64'd12}) begin
            failures++;
            $display("FAIL redirect_target got v=%b pc=%h ins=%h addr=%h want v=1 pc=2c ins=%h addr=c",
                     id_valid, id_pc, id_instruction, imem_addr, mem[11]);
        end
    endtask

    task automatic test_out_of_range();
        redirect_valid = 1; redirect_target = 64'hFFC;
        tick();
        redirect_valid = 0;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'hFFC, mem[MS-1], 64'h400}) begin
            failures++;
            $display("FAIL last_word got pc=%h ins=%h addr=%h want pc=ffc ins=%h addr=400",
                     id_pc, id_instruction, imem_addr, mem[MS-1]);
        end
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'h1000, NOP, 64'h401}) begin
            failures++;
            $display("FAIL out_of_range got v=%b pc=%h ins=%h addr=%h want v=1 pc=1000 ins=13 addr=401",
                     id_valid, id_pc, id_instruction, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        checks++;
        if ({id_valid, imem_addr} !== {1'b0, 64'h3FFF_FFFF_FFFF_FFFF}) begin
            failures++;
            $display("FAIL wrap_align got v=%b addr=%h want v=0 addr=3fffffffffffffff", id_valid, imem_addr);
        end
        redirect_valid = 0;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h0}) begin
            failures++;
            $display("FAIL wrap_fetch got pc=%h ins=%h addr=%h want pc=fffffffffffffffc ins=13 addr=0",
                     id_pc, id_instruction, imem_addr);
        end
        tick();
        checks++;
        if ({id_pc, id_instruction, imem_addr} !== {64'h0, mem[0], 64'h1}) begin
            failures++;
            $display("FAIL wrap_zero got pc=%h ins=%h addr=%h want pc=0 ins=%h addr=1",
                     id_pc, id_instruction, imem_addr, mem[0]);
        end
    endtask

    task automatic test_halt();
        halt_req = 1; id_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({halted, id_valid, imem_addr} !== {1'b1, 1'b0, 64'h1}) begin
                failures++;
                $display("FAIL halt_enter%0d got halted=%b v=%b addr=%h want halted=1 v=0 addr=1",
                         k, halted, id_valid, imem_addr);
            end
        end
        redirect_valid = 1; redirect_target = 64'h40;
        tick();
        checks++;
        if ({halted, id_valid, imem_addr} !== {1'b1, 1'b0, 64'h10}) begin
            failures++;
            $display("FAIL halt_redirect got halted=%b v=%b addr=%h want halted=1 v=0 addr=10",
                     halted, id_valid, imem_addr);
        end
        redirect_valid = 0; halt_req = 0;
        tick();
        tick();
        checks++;
        if ({halted, id_valid, id_pc, id_instruction} !== {1'b0, 1'b1, 64'h40, mem[16]}) begin
            failures++;
            $display("FAIL halt_resume got halted=%b v=%b pc=%h ins=%h want halted=0 v=1 pc=40 ins=%h",
                     halted, id_valid, id_pc, id_instruction, mem[16]);
        end
        halt_req = 1; redirect_valid = 1; redirect_target = 64'h80;
        tick();
        checks++;
        if ({halted, id_valid, imem_addr} !== {1'b0, 1'b0, 64'h20}) begin
            failures++;
            $display("FAIL halt_with_redirect got halted=%b v=%b addr=%h want halted=0 v=0 addr=20",
                     halted, id_valid, imem_addr);
        end
        redirect_valid = 0;
        tick();
        checks++;
        if ({halted, imem_addr} !== {1'b1, 64'h20}) begin
            failures++;
            $display("FAIL halt_deferred got halted=%b addr=%h want halted=1 addr=20", halted, imem_addr);
        end
        halt_req = 0;
        tick(); tick();
        halt_req = 1; id_ready = 0;
        tick();
        checks++;
        if ({halted, id_valid, id_pc} !== {1'b0, 1'b1, 64'h80}) begin
            failures++;
            $display("FAIL halt_drain_wait got halted=%b v=%b pc=%h want halted=0 v=1 pc=80",
                     halted, id_valid, id_pc);
        end
        id_ready = 1;
        tick();
        checks++;
        if ({halted, id_valid} !== {1'b1, 1'b0}) begin
            failures++;
            $display("FAIL halt_drained got halted=%b v=%b want halted=1 v=0", halted, id_valid);
        end
        halt_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        id_ready = 1;
        tick();
        id_ready = 0;
        tick();
        reset = 1;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instruction, imem_addr, halted} !== {1'b0, 64'h0, NOP, 64'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_stall got v=%b pc=%h ins=%h addr=%h halted=%b want v=0 pc=0 ins=13 addr=0 halted=0",
                     id_valid, id_pc, id_instruction, imem_addr, halted);
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
            failures++;
            $display("FAIL perf_reset got fetch=%0d stall=%0d want 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        reset = 0; id_ready = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            reset          = ($urandom_range(0, 149) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) redirect_target = {$urandom, $urandom};
            else                           redirect_target = 64'($urandom_range(0, 4*MS + 64));
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            id_ready = ($urandom_range(0, 9) < 7);
            tick();
            checks++;
            if ({id_valid, id_pc, id_instruction, imem_addr, halted} !==
                {m_valid, m_idpc, m_instr, m_pc / 4, m_halted}) begin
                failures++;
                $display("FAIL random_cycle%0d got v=%b pc=%h ins=%h addr=%h h=%b want v=%b pc=%h ins=%h addr=%h h=%b",
                         n, id_valid, id_pc, id_instruction, imem_addr, halted,
                         m_valid, m_idpc, m_instr, m_pc / 4, m_halted);
            end
`ifdef IFETCH_PERF_EN
            checks++;
            if ({perf_fetch_cnt, perf_stall_cnt} !== {m_fc, m_sc}) begin
                failures++;
                $display("FAIL random_perf%0d got fetch=%0d stall=%0d want fetch=%0d stall=%0d",
                         n, perf_fetch_cnt, perf_stall_cnt, m_fc, m_sc);
            end
`endif
        end
        reset = 0; redirect_valid = 0; halt_req = 0; id_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = $urandom;
        m_pc = '0; m_valid = 0; m_instr = NOP; m_idpc = '0;
        m_mode = M_BOOT; m_halted = 0; m_fc = 0; m_sc = 0;
        reset = 1; redirect_valid = 0; redirect_target = '0; halt_req = 0; id_ready = 1;

        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_out_of_range();
        test_wrap();
        test_halt();
        test_reset_mid_stall();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
